// File: rtl/trap_seq_pkg.sv
// trap_seq_pkg: CSR addresses, trap cause codes and shared types for the trap sequencer
package trap_seq_pkg;
  localparam int XLEN = 64;
  localparam int CSR_ADDR_W = 12;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE = 12'h342;
  localparam logic [XLEN-1:0] CAUSE_MTI = 64'h8000_0000_0000_0007;
  localparam logic [XLEN-1:0] CAUSE_ECALL = 64'd11;
  typedef enum logic {K_TRAP, K_RET} kind_t;
endpackage

// File: rtl/trap_seq_if.sv
// trap_seq_if: commit-boundary event, CSR view and CSR write/redirect port of the trap sequencer
interface trap_seq_if;
  import trap_seq_pkg::*;
  logic i_instr_valid;
  logic [XLEN-1:0] i_pc;
  logic i_ecall;
  logic i_mret;
  logic i_global_int_en;
  logic i_mtime_int_en;
  logic i_mtime_int_pend;
  logic [XLEN-1:0] i_csr_mtvec;
  logic [XLEN-1:0] i_csr_mepc;
  logic [XLEN-1:0] i_csr_mstatus;
  logic i_cpu_csr_wen;
  logic o_csr_wen;
  logic [CSR_ADDR_W-1:0] o_csr_waddr;
  logic [XLEN-1:0] o_csr_wdata;
  logic o_busy;
  logic o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  modport master (
    output i_instr_valid, i_pc, i_ecall, i_mret, i_global_int_en, i_mtime_int_en, i_mtime_int_pend,
    output i_csr_mtvec, i_csr_mepc, i_csr_mstatus, i_cpu_csr_wen,
    input o_csr_wen, o_csr_waddr, o_csr_wdata, o_busy, o_redirect, o_redirect_pc
  );
  modport slave (
    input i_instr_valid, i_pc, i_ecall, i_mret, i_global_int_en, i_mtime_int_en, i_mtime_int_pend,
    input i_csr_mtvec, i_csr_mepc, i_csr_mstatus, i_cpu_csr_wen,
    output o_csr_wen, o_csr_waddr, o_csr_wdata, o_busy, o_redirect, o_redirect_pc
  );
endinterface

// File: rtl/trap_seq.sv
// trap_seq: sequences mepc/mcause/mstatus writes and the fetch redirect for traps and MRET
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  trap_seq_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MEPC = 3'd1;
  localparam logic [2:0] S_MCAUSE = 3'd2;
  localparam logic [2:0] S_MSTATUS = 3'd3;
  localparam logic [2:0] S_REDIR = 3'd4;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    W_MEPC = S_MEPC,
    W_MCAUSE = S_MCAUSE,
    W_MSTATUS = S_MSTATUS,
    REDIRECT = S_REDIR
  } state_t;
  state_t state;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] cause;
  logic is_int;
  kind_t kind;
  logic irq;
  logic take;
  logic [XLEN-1:0] ms;
  logic [XLEN-1:0] ms_trap;
  logic [XLEN-1:0] ms_ret;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_pc;
  assign irq = bus.i_global_int_en & bus.i_mtime_int_en & bus.i_mtime_int_pend;
  assign take = bus.i_instr_valid & (irq | bus.i_ecall);
  assign ms = bus.i_csr_mstatus;
  assign ms_trap = {ms[63:13], 2'b11, ms[10:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
  assign ms_ret = {ms[63:13], 2'b11, ms[10:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
  assign base = {bus.i_csr_mtvec[63:2], 2'b00};
  assign trap_pc = (VECTORED_EN && bus.i_csr_mtvec[1:0] == 2'b01 && is_int) ? base + {56'd0, cause[5:0], 2'b00} : base;
  // Event capture and write sequencing; write states stall while the CPU owns the CSR file
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      epc <= '0;
      cause <= '0;
      is_int <= 1'b0;
      kind <= K_TRAP;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            epc <= bus.i_pc;
            cause <= irq ? CAUSE_MTI : CAUSE_ECALL;
            is_int <= irq;
            kind <= K_TRAP;
            state <= W_MEPC;
          end else if (bus.i_instr_valid && bus.i_mret) begin
            kind <= K_RET;
            state <= W_MSTATUS;
          end
        end
        W_MEPC: state <= bus.i_cpu_csr_wen ? W_MEPC : W_MCAUSE;
        W_MCAUSE: state <= bus.i_cpu_csr_wen ? W_MCAUSE : W_MSTATUS;
        W_MSTATUS: state <= bus.i_cpu_csr_wen ? W_MSTATUS : REDIRECT;
        default: state <= IDLE;
      endcase
    end
  end
  // Output decode from the current state; mstatus and mepc are taken live from the CSR file
  always_comb begin
    bus.o_busy = state != IDLE;
    bus.o_csr_wen = state == W_MEPC || state == W_MCAUSE || state == W_MSTATUS;
    bus.o_csr_waddr = state == W_MEPC ? CSR_MEPC : state == W_MCAUSE ? CSR_MCAUSE : state == W_MSTATUS ? CSR_MSTATUS : '0;
    bus.o_csr_wdata = state == W_MEPC ? epc : state == W_MCAUSE ? cause : state == W_MSTATUS ? (kind == K_RET ? ms_ret : ms_trap) : '0;
    bus.o_redirect = state == REDIRECT;
    bus.o_redirect_pc = state != REDIRECT ? '0 : kind == K_RET ? bus.i_csr_mepc : trap_pc;
  end
endmodule

// File: tb/tb_trap_seq.sv
// tb_trap_seq: directed and randomized checks of trap_seq against a write-queue reference model
module tb_trap_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  int lat;
  trap_seq_if bus ();
  trap_seq #(.VECTORED_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] trap_ms(input logic [63:0] m);
    trap_ms = m;
    trap_ms[7] = m[3];
    trap_ms[3] = 1'b0;
    trap_ms[12:11] = 2'b11;
  endfunction
  function automatic logic [63:0] ret_ms(input logic [63:0] m);
    ret_ms = m;
    ret_ms[3] = m[7];
    ret_ms[7] = 1'b1;
    ret_ms[12:11] = 2'b11;
  endfunction
  task automatic idle_inputs();
    bus.i_instr_valid = 1'b0;
    bus.i_ecall = 1'b0;
    bus.i_mret = 1'b0;
    bus.i_cpu_csr_wen = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(bus.o_busy), 0);
    chk({tag, "_wen"}, 64'(bus.o_csr_wen), 0);
    chk({tag, "_redir"}, 64'(bus.o_redirect), 0);
  endtask
  task automatic run_event(input logic mie, mtie, mtip, ec, mr, input logic [63:0] pc, mtvec, mepc, ms, stall,
                           input bit noise, output int lat_o);
    logic irq;
    logic [63:0] cause, tgt;
    logic [11:0] qa[$];
    logic [63:0] qd[$];
    bit done;
    irq = mie & mtie & mtip;
    cause = irq ? 64'h8000_0000_0000_0007 : 64'd11;
    tgt = {mtvec[63:2], 2'b00} + ((mtvec[1:0] == 2'b01 && irq) ? cause * 4 : 64'd0);
    qa = {};
    qd = {};
    if (irq | ec) begin
      qa = {12'h341, 12'h342, 12'h300};
      qd = {pc, cause, trap_ms(ms)};
    end else if (mr) begin
      qa = {12'h300};
      qd = {ret_ms(ms)};
      tgt = mepc;
    end
    done = qa.size() == 0;
    lat_o = -1;
    @(negedge clk);
    bus.i_instr_valid = 1'b1;
    bus.i_ecall = ec;
    bus.i_mret = mr;
    bus.i_global_int_en = mie;
    bus.i_mtime_int_en = mtie;
    bus.i_mtime_int_pend = mtip;
    bus.i_pc = pc;
    bus.i_csr_mtvec = mtvec;
    bus.i_csr_mepc = mepc;
    bus.i_csr_mstatus = ms;
    bus.i_cpu_csr_wen = stall[0];
    #1;
    check_idle("take");
    for (int c = 1; c < 64 && !done; c++) begin
      @(negedge clk);
      bus.i_instr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_ecall = 1'($urandom_range(0, 1));
      bus.i_mret = 1'($urandom_range(0, 1));
      bus.i_pc = {$urandom, $urandom};
      bus.i_cpu_csr_wen = stall[c];
      #1;
      if (qa.size() > 0) begin
        chk("wr_wen", 64'(bus.o_csr_wen), 1);
        chk("wr_addr", 64'(bus.o_csr_waddr), 64'(qa[0]));
        chk("wr_data", bus.o_csr_wdata, qd[0]);
        chk("wr_busy", 64'(bus.o_busy), 1);
        chk("wr_redir", 64'(bus.o_redirect), 0);
        if (!stall[c]) begin
          void'(qa.pop_front());
          void'(qd.pop_front());
        end
      end else begin
        chk("rd_redir", 64'(bus.o_redirect), 1);
        chk("rd_pc", bus.o_redirect_pc, tgt);
        chk("rd_wen", 64'(bus.o_csr_wen), 0);
        chk("rd_addr", 64'(bus.o_csr_waddr), 0);
        chk("rd_data", bus.o_csr_wdata, 0);
        chk("rd_busy", 64'(bus.o_busy), 1);
        lat_o = c;
        done = 1'b1;
      end
    end
    if (!done) chk("timeout", 0, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    check_idle("after");
  endtask
  initial begin
    idle_inputs();
    bus.i_pc = '0;
    bus.i_global_int_en = 1'b0;
    bus.i_mtime_int_en = 1'b0;
    bus.i_mtime_int_pend = 1'b0;
    bus.i_csr_mtvec = '0;
    bus.i_csr_mepc = '0;
    bus.i_csr_mstatus = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_idle("reset");
    chk("reset_waddr", 64'(bus.o_csr_waddr), 0);
    chk("reset_wdata", bus.o_csr_wdata, 0);
    chk("reset_rpc", bus.o_redirect_pc, 0);
    rst = 1'b0;
    run_event(0, 0, 0, 1, 0, 64'h8000_0010, 64'h8000_1000, 64'h0, 64'h1808, 64'd0, 0, lat);
    chk("ecall_lat", 64'(lat), 4);
    run_event(1, 1, 1, 0, 0, 64'h8000_0020, 64'h8000_1001, 64'h0, 64'h1808, 64'd0, 0, lat);
    chk("irq_lat", 64'(lat), 4);
    run_event(0, 0, 0, 0, 1, 64'h8000_0030, 64'h8000_1000, 64'h8000_0014, 64'h1880, 64'd0, 0, lat);
    chk("mret_lat", 64'(lat), 2);
    run_event(0, 0, 0, 1, 0, 64'h8000_0040, 64'h8000_1000, 64'h0, 64'h1808, 64'b11100, 0, lat);
    chk("stall_lat", 64'(lat), 7);
    run_event(1, 1, 1, 1, 1, 64'h8000_0050, 64'h8000_2001, 64'h0, 64'h0008, 64'd0, 1, lat);
    chk("both_lat", 64'(lat), 4);
    run_event(1, 1, 1, 0, 0, 64'h8000_0060, 64'h8000_3000, 64'h0, 64'h0, 64'd0, 1, lat);
    run_event(0, 1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 64'h0, 64'd0, 1, lat);
    run_event(0, 0, 0, 0, 0, 64'h8000_0070, 64'h8000_1000, 64'h0, 64'h0, 64'd0, 0, lat);
    @(negedge clk);
    bus.i_instr_valid = 1'b1;
    bus.i_ecall = 1'b1;
    bus.i_global_int_en = 1'b0;
    #1;
    check_idle("rst_take");
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    chk("rst_mcause", 64'(bus.o_csr_waddr), 64'h342);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("rst_abort");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check_idle("rst_quiet");
    end
    for (int n = 0; n < 30; n++) begin
      logic [63:0] mt;
      mt = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) mt[1:0] = 2'b01;
      run_event(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, mt,
                {$urandom, $urandom}, {$urandom, $urandom},
                {32'd0, $urandom & $urandom & $urandom}, 1, lat);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 The module SHALL take parameter VECTORED_EN, default 1, which enables mtvec vectored mode for interrupts when set to 1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_instr_valid  input  1  an instruction sits at the commit boundary this cycle.
REQ-005 i_pc  input  64  PC of that instruction.
REQ-006 i_ecall / i_mret  input  1 each  the instruction is ECALL / MRET; both are qualified by i_instr_valid.
REQ-007 i_global_int_en, i_mtime_int_en, i_mtime_int_pend  input  1 each  mstatus.MIE, mie.MTIE and mip.MTIP as currently held by the CSR file.
REQ-008 i_csr_mtvec, i_csr_mepc, i_csr_mstatus  input  64 each  current CSR values.
REQ-009 i_cpu_csr_wen  input  1  the CPU's CSR write this cycle; it takes priority over this block at the CSR file.
REQ-010 o_csr_wen  output  1, o_csr_waddr  output  12, o_csr_wdata  output  64  write port into the CSR file's secondary (clint) port.
REQ-011 o_busy  output  1  pipeline hold; high in every state except IDLE.
REQ-012 o_redirect  output  1  one-cycle pulse requesting a fetch redirect.
REQ-013 o_redirect_pc  output  64  redirect target; valid only while o_redirect is high.

Function
REQ-014 The FSM SHALL have the states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS and REDIRECT.
REQ-015 In IDLE, a trap SHALL be taken when i_instr_valid & ((i_global_int_en & i_mtime_int_en & i_mtime_int_pend) | i_ecall).
- Interrupt beats ECALL; interrupt and ECALL both beat MRET.
REQ-016 On trap take, the block SHALL capture:
- epc = i_pc;
- cause = 64'h8000_0000_0000_0007 for an interrupt, or 64'd11 for ECALL;
- is_int.
It SHALL then go to W_MEPC.
REQ-017 In IDLE, an MRET with no trap condition SHALL go to W_MSTATUS with kind=RET.
REQ-018 W_MEPC SHALL drive wen=1, waddr=0x341, wdata=epc.
REQ-019 W_MCAUSE SHALL drive wen=1, waddr=0x342, wdata=cause.
REQ-020 W_MSTATUS SHALL drive wen=1, waddr=0x300, with wdata derived from i_csr_mstatus in that same cycle:
- trap: MPIE(bit7)=old MIE(bit3), MIE=0, MPP[12:11]=2'b11;
- ret: MIE=old MPIE, MPIE=1, MPP=2'b11.
All other bits SHALL pass through unchanged.
REQ-021 Each write state SHALL advance only on a cycle with i_cpu_csr_wen=0.
- Otherwise it holds with all outputs unchanged and retries; there is no retry limit.
REQ-022 The advance order SHALL be W_MEPC -> W_MCAUSE -> W_MSTATUS -> REDIRECT.
REQ-023 REDIRECT SHALL assert o_redirect=1 for exactly one cycle, drive o_csr_wen=0, and then go to IDLE.
REQ-024 The redirect target SHALL be:
- trap: {i_csr_mtvec[63:2],2'b00};
- trap with VECTORED_EN=1, i_csr_mtvec[1:0]==2'b01 and is_int: base + (cause[5:0]<<2), i.e. base+0x1C;
- ret: i_csr_mepc as sampled in REDIRECT.
REQ-025 Uncontended latency SHALL be: trap entry has o_redirect in cycle 4 after the take cycle; MRET has o_redirect in cycle 2.
REQ-026 The block SHALL accept a new event in IDLE only, and never in the same cycle as REDIRECT.
- Events arriving while busy are ignored; the pipeline is held by o_busy.
REQ-027 o_csr_wen SHALL be 0 in IDLE and REDIRECT, with o_csr_waddr=0 and o_csr_wdata=0 in those states.
REQ-028 Address and cause arithmetic SHALL be 64-bit and wrap modulo 2^64.

Reset
REQ-029 While rst=1, the block SHALL set state=IDLE; epc=0; cause=0; is_int=0; kind=TRAP; all outputs 0.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence at the next edge with no further CSR write or redirect.

Structure
REQ-031 The CSR addresses (0x300, 0x341, 0x342, 0x305) and the cause codes SHALL live in the shared defines file alongside the existing CSR address constants.
REQ-032 The state encoding SHALL be localparams in this module.
REQ-033 The module SHALL contain no sub-modules; the mstatus update function SHALL be inline combinational logic.

Verification
REQ-034 ECALL at pc=0x8000_0010, mtvec=0x8000_1000, mstatus=0x1808 -> writes mepc=0x8000_0010, mcause=11, mstatus=0x1880; redirect to 0x8000_1000 at cycle 4.
REQ-035 Timer interrupt with MIE=MTIE=MTIP=1, mtvec=0x8000_1001, VECTORED_EN=1 -> mcause=0x8000_0000_0000_0007; redirect to 0x8000_101C.
REQ-036 MRET with mstatus=0x1880, mepc=0x8000_0014 -> single write mstatus=0x1888; redirect to 0x8000_0014 at cycle 2.
REQ-037 i_cpu_csr_wen held high for 3 cycles during W_MCAUSE -> the mcause write is held 3 cycles, the sequence completes afterwards, and the redirect arrives at cycle 7.
REQ-038 Interrupt and ECALL in the same cycle -> interrupt taken with cause 0x8000_0000_0000_0007; a second ECALL while busy -> ignored.
REQ-039 rst asserted in W_MCAUSE -> no mstatus write, no redirect; o_busy=0 the next cycle.
